sync_fifo_ctrl: RTL

//  FIFO controller that drives an external two-port RAM: port A write-only, port B read-only.

---
 rtl/fifo_pkg.sv | 6 +
 rtl/sync_fifo_ctrl_if.sv | 25 ++
 rtl/fifo_wrap_ptr.sv | 32 +++
 rtl/sync_fifo_ctrl.sv | 103 ++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing constants for the streaming FIFO controller and its two-port RAM.
package fifo_pkg;
   localparam int unsigned FIFO_DW    = 8;
   localparam int unsigned FIFO_AW    = 6;
   localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;
endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Upstream sink / downstream source valid-ready handshake bundle for sync_fifo_ctrl.
interface sync_fifo_ctrl_if
   import fifo_pkg::*;
#(
   parameter int unsigned DW = FIFO_DW
);
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_ready;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_ready;

   // Environment side: produces upstream words, consumes downstream words.
   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data
   );

   // Controller side.
   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data
   );
endinterface

// File: rtl/fifo_wrap_ptr.sv
// AW-bit wrapping address counter with increment and synchronous clear.
module fifo_wrap_ptr #(
   parameter int unsigned AW = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   input  logic          clr,
   output logic [AW-1:0] ptr
);
   logic [AW-1:0] cnt_q;
   logic [AW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + AW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign ptr = cnt_q;
endmodule

// File: rtl/sync_fifo_ctrl.sv
// Streaming FIFO controller around an external two-port RAM (A write, B registered read).
// Optional synchronous flush port enabled by defining SYNC_FIFO_CTRL_FLUSH_EN.
module sync_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned DW = FIFO_DW,
   parameter int unsigned AW = FIFO_AW
) (
   input  logic                clk,
   input  logic                rst_n,
`ifdef SYNC_FIFO_CTRL_FLUSH_EN
   input  logic                flush,
`endif
   sync_fifo_ctrl_if.slave     bus,
   output logic                ram_we_a,
   output logic [AW-1:0]       ram_addr_a,
   output logic [DW-1:0]       ram_data_a,
   output logic                ram_rd_b,
   output logic [AW-1:0]       ram_addr_b,
   input  logic [DW-1:0]       ram_qb,
   output logic [AW:0]         level
);
   localparam int unsigned DEPTH = 1 << AW;

   logic [AW:0]   ram_cnt_q;
   logic [AW:0]   ram_cnt_d;
   logic          m_valid_q;
   logic          m_valid_d;
   logic          flush_c;
   logic          full_c;
   logic          wr_c;
   logic          rd_c;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

`ifdef SYNC_FIFO_CTRL_FLUSH_EN
   assign flush_c = flush;
`else
   assign flush_c = 1'b0;
`endif

   // Handshake decode; everything is held off while in reset or flushing.
   assign full_c      = (ram_cnt_q == (AW+1)'(DEPTH));
   assign bus.s_ready = rst_n & ~flush_c & ~full_c;
   assign wr_c        = bus.s_valid & bus.s_ready;
   assign rd_c        = rst_n & ~flush_c & (ram_cnt_q != '0) & (~m_valid_q | bus.m_ready);

   always_comb begin
      m_valid_d = m_valid_q;
      ram_cnt_d = ram_cnt_q;
      if (flush_c) begin
         m_valid_d = 1'b0;
         ram_cnt_d = '0;
      end else begin
         if (rd_c) begin
            m_valid_d = 1'b1;
         end else if (bus.m_ready) begin
            m_valid_d = 1'b0;
         end
         unique case ({wr_c, rd_c})
            2'b10:   ram_cnt_d = ram_cnt_q + (AW+1)'(1);
            2'b01:   ram_cnt_d = ram_cnt_q - (AW+1)'(1);
            default: ram_cnt_d = ram_cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_cnt_q <= '0;
         m_valid_q <= 1'b0;
      end else begin
         ram_cnt_q <= ram_cnt_d;
         m_valid_q <= m_valid_d;
      end
   end

   fifo_wrap_ptr #(.AW(AW)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (wr_c),
      .clr   (flush_c),
      .ptr   (wr_ptr)
   );

   fifo_wrap_ptr #(.AW(AW)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (rd_c),
      .clr   (flush_c),
      .ptr   (rd_ptr)
   );

   assign ram_we_a    = wr_c;
   assign ram_addr_a  = wr_ptr;
   assign ram_data_a  = bus.s_data;
   assign ram_rd_b    = rd_c;
   assign ram_addr_b  = rd_ptr;
   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = ram_qb;
   // Output register counts as one buffered word on top of the RAM contents.
   assign level       = rst_n ? (ram_cnt_q + (AW+1)'(m_valid_q)) : '0;
endmodule
